// File: rtl/flash_read_arbiter_if.sv
// Request/grant bus for the two-requester SPI flash read arbiter, plus the SPI pins.
// slave is the arbiter's view; master is the requester/flash side.
interface flash_read_arbiter_if;
  logic        req0, req1;
  logic [23:0] addr0, addr1;
  logic [7:0]  len0, len1;
  logic [1:0]  gnt;
  logic [1:0]  done;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        busy;
  logic        flashClk;
  logic        flashMosi;
  logic        flashCs;
  logic        flashMiso;

  modport slave (
    input  req0, req1, addr0, addr1, len0, len1, flashMiso,
    output gnt, done, rd_data, rd_valid, busy, flashClk, flashMosi, flashCs
  );

  modport master (
    output req0, req1, addr0, addr1, len0, len1, flashMiso,
    input  gnt, done, rd_data, rd_valid, busy, flashClk, flashMosi, flashCs
  );
endinterface

// File: rtl/flash_read_arbiter.sv
// Round-robin arbiter granting two requesters access to an SPI flash (mode 0, cmd 0x03).
// Each SPI bit spans two clk cycles; every output comes straight from a flop.
module flash_read_arbiter #(
  parameter logic [31:0] STARTUP_WAIT = 32'd10000000,
  parameter int unsigned CS_GAP       = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  flash_read_arbiter_if.slave bus
);
  typedef enum logic [2:0] {POWERUP, IDLE, CMD, ADDR, READ, GAP} state_e;
  localparam logic [7:0] READ_CMD = 8'h03;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        last_q, last_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  done_q, done_d;
  logic [7:0]  len_q, len_d;
  logic [31:0] sh_q, sh_d;
  logic [4:0]  bit_q, bit_d;
  logic        phase_q, phase_d;
  logic [8:0]  byte_q, byte_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        busy_q, busy_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        cs_q, cs_d;

  logic        win1;
  logic [31:0] hdr;
  logic        last_byte;

  // last_q holds the index of the previously granted requester; on a tie it loses.
  assign win1      = bus.req1 & (~bus.req0 | ~last_q);
  assign hdr       = {READ_CMD, win1 ? bus.addr1 : bus.addr0};
  assign last_byte = rd_valid_q && (byte_q == ({1'b0, len_q} + 9'd1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    done_d     = 2'b00;
    len_d      = len_q;
    sh_d       = sh_q;
    bit_d      = bit_q;
    phase_d    = phase_q;
    byte_d     = byte_q;
    rx_d       = rx_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_d       = cs_q;

    case (state_q)
      POWERUP: begin
        if (cnt_q == STARTUP_WAIT - 32'd1) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          gnt_d   = win1 ? 2'b10 : 2'b01;
          last_d  = win1;
          len_d   = win1 ? bus.len1 : bus.len0;
          mosi_d  = hdr[31];
          sh_d    = {hdr[30:0], 1'b0};
          bit_d   = '0;
          byte_d  = '0;
          phase_d = 1'b0;
          sclk_d  = 1'b0;
          cs_d    = 1'b0;
          state_d = CMD;
        end
      end
      CMD, ADDR: begin
        if (!phase_q) begin
          sclk_d  = 1'b1;
          phase_d = 1'b1;
        end else begin
          sclk_d  = 1'b0;
          phase_d = 1'b0;
          if (bit_q == 5'd31) begin
            mosi_d  = 1'b0;
            bit_d   = '0;
            state_d = READ;
          end else begin
            mosi_d = sh_q[31];
            sh_d   = {sh_q[30:0], 1'b0};
            bit_d  = bit_q + 5'd1;
            if (bit_q == 5'd7) state_d = ADDR;
          end
        end
      end
      READ: begin
        // Completion takes priority over starting another SPI bit.
        if (last_byte) begin
          done_d  = gnt_q;
          gnt_d   = 2'b00;
          cs_d    = 1'b1;
          sclk_d  = 1'b0;
          phase_d = 1'b0;
          cnt_d   = '0;
          state_d = GAP;
        end else if (!phase_q) begin
          sclk_d  = 1'b1;
          phase_d = 1'b1;
        end else begin
          sclk_d  = 1'b0;
          phase_d = 1'b0;
          rx_d    = {rx_q[6:0], bus.flashMiso};
          bit_d   = bit_q + 5'd1;
          if (bit_q[2:0] == 3'd7) begin
            rd_valid_d = 1'b1;
            rd_data_d  = {rx_q[6:0], bus.flashMiso};
            byte_d     = byte_q + 9'd1;
            bit_d      = '0;
          end
        end
      end
      GAP: begin
        if (cnt_q == CS_GAP - 1) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = POWERUP;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= POWERUP;
      cnt_q      <= '0;
      last_q     <= 1'b1;
      gnt_q      <= 2'b00;
      done_q     <= 2'b00;
      len_q      <= '0;
      sh_q       <= '0;
      bit_q      <= '0;
      phase_q    <= 1'b0;
      byte_q     <= '0;
      rx_q       <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      len_q      <= len_d;
      sh_q       <= sh_d;
      bit_q      <= bit_d;
      phase_q    <= phase_d;
      byte_q     <= byte_d;
      rx_q       <= rx_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_q       <= cs_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.busy      = busy_q;
  assign bus.flashClk  = sclk_q;
  assign bus.flashMosi = mosi_q;
  assign bus.flashCs   = cs_q;
endmodule

// File: tb/tb_flash_read_arbiter.sv
// Directed bench for flash_read_arbiter with a behavioural SPI flash returning (addr & 0xFF).
module tb_flash_read_arbiter;
  logic clk;
  logic rst_n;

  flash_read_arbiter_if bus ();

  flash_read_arbiter #(
    .STARTUP_WAIT(32'd16),
    .CS_GAP      (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flash model: shifts in cmd+addr on rising flashClk, then streams bytes addr, addr+1, ...
  int          fbits = 0;
  logic [31:0] fsh   = '0;
  logic [31:0] fhdr  = '0;
  int          rb;
  logic [7:0]  fbyte;

  always @(posedge bus.flashClk or posedge bus.flashCs) begin
    if (bus.flashCs) begin
      fbits <= 0;
      fsh   <= '0;
    end else begin
      fbits <= fbits + 1;
      if (fbits < 32) fsh <= {fsh[30:0], bus.flashMosi};
      if (fbits == 31) fhdr <= {fsh[30:0], bus.flashMosi};
    end
  end

  assign rb            = fbits - 33;
  assign fbyte         = fsh[7:0] + rb[10:3];
  assign bus.flashMiso = (fbits >= 33) ? fbyte[~rb[2:0]] : 1'b0;

  // Bus monitor
  int          cyc = 0, first_cs = 0;
  int          rv_cnt = 0, rv_cyc = 0, done_cyc = 0;
  int          done0 = 0, done1 = 0;
  int          cs_len = 0, last_cs_len = 0, since_rise = 0;
  logic [7:0]  last_rd = '0;
  logic [7:0]  rd_log [1024];
  logic        p_fclk = 1'b0, p_mosi = 1'b0, p_rv = 1'b0, p_cs = 1'b1;
  logic [7:0]  viol = '0;
  logic        rise;

  assign rise = bus.flashClk && !p_fclk;

  always @(negedge clk) begin
    p_fclk <= bus.flashClk;
    p_mosi <= bus.flashMosi;
    p_rv   <= bus.rd_valid;
    p_cs   <= bus.flashCs;
    cyc    <= rst_n ? cyc + 1 : 0;
    if (!rst_n) first_cs <= 0;
    else if (!bus.flashCs && first_cs == 0) first_cs <= cyc + 1;
    if (bus.rd_valid) begin
      rv_cnt  <= rv_cnt + 1;
      last_rd <= bus.rd_data;
      rv_cyc  <= cyc;
      if (rv_cnt < 1024) rd_log[rv_cnt] <= bus.rd_data;
    end
    if (bus.done[0]) begin done0 <= done0 + 1; done_cyc <= cyc; end
    if (bus.done[1]) begin done1 <= done1 + 1; done_cyc <= cyc; end
    if (!bus.flashCs) cs_len <= cs_len + 1;
    else if (!p_cs) begin last_cs_len <= cs_len; cs_len <= 0; end
    if (rise) since_rise <= 1;
    else if (bus.flashCs) since_rise <= 0;
    else if (since_rise != 0) since_rise <= since_rise + 1;
    viol <= viol | {2'b00,
                    rise && since_rise != 0 && since_rise != 2,
                    bus.rd_valid && bus.gnt == 2'b00,
                    bus.flashCs && (bus.flashClk || bus.flashMosi),
                    rise && (bus.flashMosi != p_mosi),
                    bus.flashClk && p_fclk,
                    bus.rd_valid && p_rv};
  end

  int chk_n = 0, err_n = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_n++;
    assert (obs === exp)
    else begin
      err_n++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_done(input int n, input int budget, output logic found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      step();
      if (bus.done[n]) found = 1'b1;
    end
  endtask

  task automatic wait_cs_low(input int budget, output logic found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      step();
      if (!bus.flashCs) found = 1'b1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    int   rv0, d0;

    rst_n     = 1'b0;
    bus.req0  = 1'b0;  bus.req1  = 1'b0;
    bus.addr0 = 24'h000100; bus.len0 = 8'd3;
    bus.addr1 = 24'h0; bus.len1 = 8'd0;

    // Reset values
    steps(2);
    check("rst_cs",     32'(bus.flashCs),   32'd1);
    check("rst_fclk",   32'(bus.flashClk),  32'd0);
    check("rst_mosi",   32'(bus.flashMosi), 32'd0);
    check("rst_gnt",    32'(bus.gnt),       32'd0);
    check("rst_done",   32'(bus.done),      32'd0);
    check("rst_rv",     32'(bus.rd_valid),  32'd0);
    check("rst_rdata",  32'(bus.rd_data),   32'd0);
    check("rst_busy",   32'(bus.busy),      32'd1);

    // Power-up and single request
    bus.req0 = 1'b1;
    rst_n    = 1'b1;
    wait_done(0, 400, found);
    bus.req0 = 1'b0;
    check("t1_done_seen", 32'(found), 32'd1);
    check("t1_first_cs",  32'(first_cs), 32'd17);
    check("t1_header",    fhdr, 32'h03000100);
    check("t1_rv_cnt",    32'(rv_cnt), 32'd4);
    check("t1_byte0",     32'(rd_log[0]), 32'h00);
    check("t1_byte1",     32'(rd_log[1]), 32'h01);
    check("t1_byte2",     32'(rd_log[2]), 32'h02);
    check("t1_byte3",     32'(rd_log[3]), 32'h03);
    check("t1_done_cnt",  32'(done0), 32'd1);
    check("t1_gnt_clr",   32'(bus.gnt), 32'd0);
    check("t1_cs_len",    32'(last_cs_len), 32'd129);

    // Tie after reset: req0 first, then req1, then round-robin
    rst_n = 1'b0;
    bus.req0 = 1'b1; bus.addr0 = 24'h000010; bus.len0 = 8'd0;
    bus.req1 = 1'b1; bus.addr1 = 24'h000020; bus.len1 = 8'd1;
    steps(2);
    rst_n = 1'b1;
    wait_cs_low(40, found);
    check("t2_cs_seen", 32'(found), 32'd1);
    check("t2_gnt_first", 32'(bus.gnt), 32'b01);
    wait_done(0, 200, found);
    bus.req0 = 1'b0;
    check("t2_done0_seen", 32'(found), 32'd1);
    check("t2_rd0", 32'(last_rd), 32'h10);
    steps(4);
    check("t2_gap_gnt", 32'(bus.gnt), 32'd0);
    check("t2_gap_cs",  32'(bus.flashCs), 32'd1);
    step();
    check("t2_gnt_second", 32'(bus.gnt), 32'b10);
    bus.req0 = 1'b1; bus.addr0 = 24'h000030; bus.len0 = 8'd0;
    wait_done(1, 200, found);
    check("t2_done1_seen", 32'(found), 32'd1);
    check("t2_rd1a", 32'(rd_log[rv_cnt-2]), 32'h20);
    check("t2_rd1b", 32'(rd_log[rv_cnt-1]), 32'h21);
    bus.addr1 = 24'h000040; bus.len1 = 8'd0;
    steps(5);
    check("t2_rr_gnt0", 32'(bus.gnt), 32'b01);
    wait_done(0, 200, found);
    bus.req0 = 1'b0;
    check("t2_rd0b", 32'(last_rd), 32'h30);
    steps(5);
    check("t2_rr_gnt1", 32'(bus.gnt), 32'b10);
    wait_done(1, 200, found);
    check("t2_rd1c", 32'(last_rd), 32'h40);

    // Maximum length on requester 1
    bus.addr1 = 24'h0000F0; bus.len1 = 8'd255;
    rv0 = rv_cnt;
    wait_done(1, 5000, found);
    bus.req1 = 1'b0;
    check("t3_done_seen", 32'(found), 32'd1);
    check("t3_rv_cnt",    32'(rv_cnt - rv0), 32'd256);
    check("t3_first",     32'(rd_log[rv0]), 32'hF0);
    check("t3_last",      32'(last_rd), 32'hEF);
    check("t3_cs_len",    32'(last_cs_len), 32'd4161);

    // Reset during READ byte 2
    bus.req0 = 1'b1; bus.addr0 = 24'h000050; bus.len0 = 8'd7;
    rv0 = rv_cnt; d0 = done0;
    for (int i = 0; i < 500 && (rv_cnt - rv0) < 2; i++) step();
    steps(3);
    #2 rst_n = 1'b0;
    #1;
    check("t4_cs_async",   32'(bus.flashCs),  32'd1);
    check("t4_fclk_async", 32'(bus.flashClk), 32'd0);
    check("t4_gnt_async",  32'(bus.gnt),      32'd0);
    check("t4_busy_async", 32'(bus.busy),     32'd1);
    steps(3);
    check("t4_no_done", 32'(done0 - d0), 32'd0);
    check("t4_no_rv",   32'(rv_cnt - rv0), 32'd2);
    rst_n = 1'b1;
    wait_cs_low(40, found);
    check("t4_restart_cs", 32'(first_cs), 32'd17);
    wait_done(0, 400, found);
    bus.req0 = 1'b0;
    check("t4_done_seen", 32'(found), 32'd1);
    check("t4_rv_cnt",    32'(rv_cnt - rv0), 32'd10);
    check("t4_last",      32'(last_rd), 32'h57);

    // Request dropped mid-READ, single byte
    bus.req0 = 1'b1; bus.addr0 = 24'h000077; bus.len0 = 8'd0;
    rv0 = rv_cnt; d0 = done0;
    wait_cs_low(40, found);
    steps(70);
    bus.req0 = 1'b0;
    wait_done(0, 100, found);
    check("t5_done_seen", 32'(found), 32'd1);
    check("t5_rv_cnt",    32'(rv_cnt - rv0), 32'd1);
    check("t5_data",      32'(last_rd), 32'h77);
    check("t5_done_after_rv", 32'(done_cyc - rv_cyc), 32'd1);
    steps(12);
    check("t5_idle_gnt",  32'(bus.gnt),  32'd0);
    check("t5_idle_busy", 32'(bus.busy), 32'd0);

    check("total_done0", 32'(done0), 32'd5);
    check("total_done1", 32'(done1), 32'd3);
    check("spi_protocol", 32'(viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", chk_n, err_n);
    $finish;
  end
endmodule
